dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each granted access goes through IDLE -> ACCESS -> RESP, so one access completes every three cycles.
module dmem_arbiter #(
   parameter int unsigned DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_ack,
   output logic        p0_err,
   output logic [31:0] p0_rdata,

   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_ack,
   output logic        p1_err,
   output logic [31:0] p1_rdata,

   output logic [31:0] DMEM_address,
   output logic [31:0] DMEM_data_in,
   output logic        DMEM_mem_write,
   output logic        DMEM_mem_read,
   input  logic [31:0] DMEM_data_out,

   output logic        busy
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            last_q, last_d;      // 1: port 1 was granted most recently
   logic            gnt_q, gnt_d;
   logic            we_q, we_d;
   logic            in_range_q, in_range_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   resp_q, resp_d;
   logic [1:0]      ack_q, ack_d;
   logic [1:0]      err_q, err_d;

   logic            grant_p1;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic            access;

   // Next-state and latch logic; port 1 wins contention only if port 0 was granted last.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      we_d       = we_q;
      in_range_d = in_range_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      resp_d     = resp_q;
      ack_d      = 2'b00;
      err_d      = 2'b00;

      grant_p1  = p1_req & (~p0_req | ~last_q);
      sel_we    = grant_p1 ? p1_we    : p0_we;
      sel_addr  = grant_p1 ? p1_addr  : p0_addr;
      sel_wdata = grant_p1 ? p1_wdata : p0_wdata;

      case (state_q)
         IDLE: begin
            if (p0_req | p1_req) begin
               state_d    = ACCESS;
               last_d     = grant_p1;
               gnt_d      = grant_p1;
               we_d       = sel_we;
               addr_d     = sel_addr;
               wdata_d    = sel_wdata;
               in_range_d = (sel_addr < DEPTH_W);
            end
         end
         ACCESS: begin
            state_d = RESP;
            resp_d  = (in_range_q & ~we_q) ? DMEM_data_out : '0;
            ack_d   = gnt_q ? 2'b10 : 2'b01;
            err_d   = in_range_q ? 2'b00 : (gnt_q ? 2'b10 : 2'b01);
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         gnt_q      <= 1'b0;
         we_q       <= 1'b0;
         in_range_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         resp_q     <= '0;
         ack_q      <= 2'b00;
         err_q      <= 2'b00;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         gnt_q      <= gnt_d;
         we_q       <= we_d;
         in_range_q <= in_range_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         resp_q     <= resp_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
      end
   end

   // DMEM side is decoded from the state register so an async reset drops strobes at once.
   assign access         = (state_q == ACCESS);
   assign DMEM_address   = access ? addr_q  : '0;
   assign DMEM_data_in   = access ? wdata_q : '0;
   assign DMEM_mem_write = access &  we_q & in_range_q;
   assign DMEM_mem_read  = access & ~we_q & in_range_q;

   assign busy     = (state_q != IDLE);
   assign p0_ack   = ack_q[0];
   assign p1_ack   = ack_q[1];
   assign p0_err   = err_q[0];
   assign p1_err   = err_q[1];
   assign p0_rdata = resp_q;
   assign p1_rdata = resp_q;

endmodule
